// File: rtl/irq_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | Module   : irq_ctrl_pkg                                                  |
// | Purpose  : Shared types, constants and the mcause helper for the         |
// |            machine-mode interrupt controller.                            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

package irq_ctrl_pkg;

  // Handler sequence: take the trap, wait in the handler, then acknowledge.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    SERVICE = 2'd2,
    ACK     = 2'd3
  } irq_state_t;

  // Bit 31 of mcause marks an asynchronous trap.
  localparam logic [31:0] MCAUSE_IRQ_FLAG = 32'h8000_0000;

  // mcause value for source id, given the cause code of source 0.
  function automatic logic [31:0] cause_of(input logic [31:0] base, input logic [31:0] id);
    return MCAUSE_IRQ_FLAG | {1'b0, 31'(base + id)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/irq_prio_sel.sv
// +--------------------------------------------------------------------------+
// | Module   : irq_prio_sel                                                  |
// | Purpose  : Picks one pending source, searching upward from start_i and   |
// |            wrapping. A start of 0 gives lowest-index-wins priority.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module irq_prio_sel #(
  parameter int N_IRQ = 16,
  parameter int IDW   = 4
) (
  input  logic [N_IRQ-1:0] pending_i,
  input  logic [IDW-1:0]   start_i,
  output logic             valid_o,
  output logic [IDW-1:0]   id_o
);

  logic [IDW-1:0] idx;

  // Circular scan from start_i; the first pending source found wins.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    idx     = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      idx = IDW'((int'(start_i) + i) % N_IRQ);
      if (!valid_o && pending_i[idx]) begin
        valid_o = 1'b1;
        id_o    = idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/irq_controller.sv
// +--------------------------------------------------------------------------+
// | Module   : irq_controller                                                |
// | Purpose  : Machine-mode interrupt entry/return sequencer. Masks level    |
// |            requests with mie, grants one source, strobes irq_o for the   |
// |            CSR/PC redirect, reports mcause and acks the source on mret.  |
// | Config   : IRQ_CTRL_RR_EN defined -> round-robin selection,              |
// |            otherwise fixed priority (lowest index wins).                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int N_IRQ      = 16,
  parameter int CAUSE_BASE = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [N_IRQ-1:0] irq_req_i,
  input  logic [31:0]      mie_i,
  input  logic             stall_i,
  input  logic             mret_i,
  output logic             irq_o,
  output logic [31:0]      mcause_o,
  output logic [N_IRQ-1:0] irq_ret_o,
  output logic             busy_o
);

  localparam int IDW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  irq_state_t       state_q, state_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [31:0]      cause_q, cause_d;
  logic             irq_q, irq_d;
  logic [N_IRQ-1:0] ret_q, ret_d;
  logic             busy_q, busy_d;

  logic [N_IRQ-1:0] pending;
  logic             sel_valid;
  logic [IDW-1:0]   sel_id;
  logic [IDW-1:0]   start_ptr;
  logic             take;

  // mie bits above the source count have no meaning here.
  logic unused_mie;
  assign unused_mie = &{1'b0, mie_i[31:N_IRQ]};

  assign pending = irq_req_i & mie_i[N_IRQ-1:0];
  assign take    = (state_q == IDLE) && sel_valid && !stall_i;

  irq_prio_sel #(
    .N_IRQ (N_IRQ),
    .IDW   (IDW)
  ) u_sel (
    .pending_i (pending),
    .start_i   (start_ptr),
    .valid_o   (sel_valid),
    .id_o      (sel_id)
  );

`ifdef IRQ_CTRL_RR_EN
  logic [IDW-1:0] ptr_q, ptr_d;

  // Search start moves just past the source granted on each new entry.
  always_comb begin
    ptr_d = ptr_q;
    if (take) begin
      ptr_d = (sel_id == IDW'(N_IRQ - 1)) ? '0 : sel_id + IDW'(1);
    end
  end

  // Round-robin pointer register; id 0 has first priority out of reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign start_ptr = ptr_q;
`else
  assign start_ptr = '0;
`endif

  // Next state, latched grant and registered output values.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          id_d    = sel_id;
          cause_d = cause_of(32'(CAUSE_BASE), 32'(sel_id));
          state_d = TAKE;
        end
      end
      TAKE:    state_d = SERVICE;
      SERVICE: if (mret_i) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    irq_d  = (state_d == TAKE);
    busy_d = (state_d != IDLE);
    ret_d  = (state_d == ACK) ? (N_IRQ'(1) << id_d) : '0;
  end

  // State and output registers; reset drops any in-flight grant silently.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      id_q    <= '0;
      cause_q <= '0;
      irq_q   <= 1'b0;
      ret_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cause_q <= cause_d;
      irq_q   <= irq_d;
      ret_q   <= ret_d;
      busy_q  <= busy_d;
    end
  end

  assign irq_o     = irq_q;
  assign mcause_o  = cause_q;
  assign irq_ret_o = ret_q;
  assign busy_o    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_controller.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_irq_controller                                             |
// | Purpose  : Self-checking bench for irq_controller: directed scenarios    |
// |            with literal expectations plus randomized traffic compared    |
// |            every cycle against a behavioural model.                      |
// | Config   : IRQ_CTRL_RR_EN selects round-robin expectations.              |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic [15:0] irq_req_i = '0;
  logic [31:0] mie_i = '0;
  logic        stall_i = 1'b0;
  logic        mret_i = 1'b0;
  logic        irq_o;
  logic [31:0] mcause_o;
  logic [15:0] irq_ret_o;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  irq_controller #(.N_IRQ(16), .CAUSE_BASE(16)) dut (
    .clk_i     (clk),
    .rstn_i    (rstn_i),
    .irq_req_i (irq_req_i),
    .mie_i     (mie_i),
    .stall_i   (stall_i),
    .mret_i    (mret_i),
    .irq_o     (irq_o),
    .mcause_o  (mcause_o),
    .irq_ret_o (irq_ret_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A handler is "open" from the grant until the edge after its ack.
  bit          m_open = 0, m_acking = 0;
  int          m_edge = 0, m_take_edge = 0, m_id = 0, m_ptr = 0;
  logic [31:0] m_cause = '0;
  logic        e_irq = 0, e_busy = 0;
  logic [15:0] e_ret = '0;

  function automatic int pick(input logic [15:0] p, input int start);
    for (int i = 0; i < 16; i++) if (p[(start + i) % 16]) return (start + i) % 16;
    return 0;
  endfunction

  always @(posedge clk) begin
    logic [15:0] p;
    m_edge++;
    p = irq_req_i & mie_i[15:0];
    if (!rstn_i) begin
      m_open = 0; m_acking = 0; m_id = 0; m_ptr = 0; m_cause = '0;
      e_irq = 0; e_ret = '0; e_busy = 0;
    end else begin
      e_irq = 0;
      e_ret = '0;
      if (!m_open) begin
        if (p != 0 && !stall_i) begin
          m_id = pick(p, m_ptr);
          m_cause = 32'h8000_0000 + 32'(16 + m_id);
`ifdef IRQ_CTRL_RR_EN
          m_ptr = (m_id + 1) % 16;
`endif
          m_open = 1; m_acking = 0; m_take_edge = m_edge;
          e_irq = 1;
        end
      end else if (m_edge == m_take_edge + 1) begin
        // leaving the strobe cycle: mret here is ignored
      end else if (m_acking) begin
        m_open = 0; m_acking = 0;
      end else if (mret_i) begin
        e_ret = 16'(1) << m_id;
        m_acking = 1;
      end
      e_busy = m_open;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_irq", {31'b0, irq_o}, {31'b0, e_irq});
      chk("m_busy", {31'b0, busy_o}, {31'b0, e_busy});
      chk("m_ret", {16'b0, irq_ret_o}, {16'b0, e_ret});
      chk("m_cause", mcause_o, m_cause);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_irq(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!irq_o && n < 20);
    chk(nm, {31'b0, irq_o}, 32'd1);
  endtask

  // Called in the strobe cycle: steps into SERVICE, issues mret, finishes ACK.
  task automatic close_handler();
    @(negedge clk);
    mret_i = 1'b1;
    @(negedge clk);
    mret_i = 1'b0;
    @(negedge clk);
  endtask

  logic [31:0] exp_cause [3];
  int          seen;

  initial begin
    // 1 reset with everything requesting
    rstn_i = 1'b0; irq_req_i = 16'hFFFF; mie_i = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_irq", {31'b0, irq_o}, 32'd0);
    chk("rst_ret", {16'b0, irq_ret_o}, 32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_cause", mcause_o, 32'd0);
    cmp_en = 1'b1;
    rstn_i = 1'b1; irq_req_i = '0; mie_i = '0;
    @(negedge clk);

    // 2 single entry on source 3
    mie_i = 32'h8; irq_req_i = 16'h0008;
    @(negedge clk);
    chk("t2_irq", {31'b0, irq_o}, 32'd1);
    chk("t2_cause", mcause_o, 32'h8000_0013);
    @(negedge clk);
    chk("t2_irq_once", {31'b0, irq_o}, 32'd0);
    mret_i = 1'b1;
    @(negedge clk);
    mret_i = 1'b0;
    chk("t2_ret", {16'b0, irq_ret_o}, 32'h0008);
    irq_req_i = '0;
    @(negedge clk);
    chk("t2_busy", {31'b0, busy_o}, 32'd0);

    // 3 masking then stall
    irq_req_i = 16'h0001; mie_i = '0; seen = 0;
    repeat (20) begin @(negedge clk); if (irq_o) seen++; end
    chk("t3_masked", 32'(seen), 32'd0);
    mie_i = 32'h1; stall_i = 1'b1; seen = 0;
    repeat (5) begin @(negedge clk); if (irq_o) seen++; end
    chk("t3_stalled", 32'(seen), 32'd0);
    stall_i = 1'b0;
    @(negedge clk);
    chk("t3_irq_after_stall", {31'b0, irq_o}, 32'd1);
    irq_req_i = '0;
    close_handler();

    // 4 priority between sources 1 and 2
`ifdef IRQ_CTRL_RR_EN
    exp_cause = '{32'h8000_0011, 32'h8000_0012, 32'h8000_0011};
`else
    exp_cause = '{32'h8000_0011, 32'h8000_0011, 32'h8000_0011};
`endif
    irq_req_i = 16'h0006; mie_i = 32'hFFFF_FFFF;
    for (int r = 0; r < 3; r++) begin
      wait_irq("t4_irq");
      chk("t4_cause", mcause_o, exp_cause[r]);
      if (r == 2) irq_req_i = '0;
      close_handler();
    end

    // 5a mret while idle
    mret_i = 1'b1;
    @(negedge clk);
    mret_i = 1'b0;
    chk("t5_idle_mret_ret", {16'b0, irq_ret_o}, 32'd0);
    chk("t5_idle_mret_busy", {31'b0, busy_o}, 32'd0);

    // 5b request drop during SERVICE
    irq_req_i = 16'h0020;
    wait_irq("t5_drop_irq");
    @(negedge clk);
    irq_req_i = '0; mret_i = 1'b1;
    @(negedge clk);
    mret_i = 1'b0;
    chk("t5_drop_ret", {16'b0, irq_ret_o}, 32'h0020);
    @(negedge clk);

    // 5c reset while in SERVICE
    irq_req_i = 16'h0010;
    wait_irq("t5_rst_irq");
    @(negedge clk);
    rstn_i = 1'b0; irq_req_i = '0;
    @(negedge clk);
    rstn_i = 1'b1;
    chk("t5_rst_busy", {31'b0, busy_o}, 32'd0);
    chk("t5_rst_cause", mcause_o, 32'd0);
    @(negedge clk);
    chk("t5_rst_ret", {16'b0, irq_ret_o}, 32'd0);

    // randomized traffic, checked by the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) irq_req_i = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 29) == 0) mie_i = $urandom;
      stall_i = ($urandom_range(0, 3) == 0);
      mret_i  = ($urandom_range(0, 4) == 0);
      rstn_i  = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk);
    rstn_i = 1'b1; mret_i = 1'b0; stall_i = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
